pwm_modulator_mc: RTL and testbench



---
 rtl/pwm_modulator_mc.sv | 158 +++++++++++++++
 tb/tb_pwm_modulator_mc.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_modulator_mc.sv
// Multi-channel audio PWM modulator.
// Takes 24-bit signed audio beats over AXI-Stream and steers each one by tid
// into that channel's sample FIFO. On every frame tick, each channel pops one
// sample into its hold register. Each channel drives a registered PWM output
// by comparing the held sample against a shared free-running counter. The
// counter is used either as a linear ramp or bit-reversed.
//
// Ports:
//   m_axis_aud_aclk    clock
//   m_axis_aud_areset  synchronous active-high reset
//   m_axis_aud_tvalid  AXIS valid
//   m_axis_aud_tid     channel select; ids >= NUM_CH are accepted and dropped
//   m_axis_aud_tdata   audio word, signed sample in [27:4]
//   m_axis_aud_tready  AXIS ready (no channel FIFO full)
//   pwm_out            per-channel PWM outputs
//   frame_tick         one-cycle pulse at each frame boundary
//   underrun           per-channel pulse, FIFO was empty at the last tick
module pwm_modulator_mc #(
   parameter int unsigned NUM_CH        = 2,
   parameter int unsigned SAMPLE_W      = 16,
   parameter int unsigned FRAME_LEN     = 2268,
   parameter int unsigned FIFO_DEPTH    = 4,
   parameter int unsigned CNT_MODE      = 1,
   parameter int unsigned UNDERRUN_MODE = 0
) (
   input  logic                m_axis_aud_aclk,
   input  logic                m_axis_aud_areset,
   input  logic                m_axis_aud_tvalid,
   input  logic [2:0]          m_axis_aud_tid,
   input  logic [31:0]         m_axis_aud_tdata,
   output logic                m_axis_aud_tready,
   output logic [NUM_CH-1:0]   pwm_out,
   output logic                frame_tick,
   output logic [NUM_CH-1:0]   underrun
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned TW = $clog2(FRAME_LEN);
   localparam logic [TW-1:0]       TIMER_MAX = TW'(FRAME_LEN - 1);
   localparam logic [SAMPLE_W-1:0] MID_SCALE = SAMPLE_W'(1) << (SAMPLE_W - 1);

   logic                run_q;
   logic [TW-1:0]       timer_q;
   logic [TW-1:0]       timer_d;
   logic [SAMPLE_W-1:0] cnt_q;
   logic [SAMPLE_W-1:0] cnt_rev;
   logic [SAMPLE_W-1:0] cmp;
   logic [SAMPLE_W-1:0] in_sample;

   logic [SAMPLE_W-1:0] fifo_mem   [NUM_CH][FIFO_DEPTH];
   logic [AW-1:0]       wr_ptr     [NUM_CH];
   logic [AW-1:0]       rd_ptr     [NUM_CH];
   logic [CW-1:0]       count_q    [NUM_CH];
   logic [CW-1:0]       count_d    [NUM_CH];
   logic [SAMPLE_W-1:0] sample_reg [NUM_CH];
   logic [NUM_CH-1:0]   push;
   logic [NUM_CH-1:0]   pop;
   logic [NUM_CH-1:0]   empty;
   logic [NUM_CH-1:0]   full_d;

   // Only the retained sample bits are consumed
   wire unused_tdata = ^m_axis_aud_tdata;

   // Signed sample to offset binary: invert the sign bit, keep the top bits
   generate
      if (SAMPLE_W == 1) begin : g_w1
         assign in_sample = ~m_axis_aud_tdata[27];
      end else begin : g_wn
         assign in_sample = {~m_axis_aud_tdata[27], m_axis_aud_tdata[26 -: SAMPLE_W-1]};
      end
   endgenerate

   // Frame timer. run_q holds the timer at FRAME_LEN-1 for the first cycle
   // out of reset, so the first tick lands FRAME_LEN cycles after release.
   always_comb begin
      timer_d = timer_q;
      if (run_q) begin
         timer_d = (timer_q == '0) ? TIMER_MAX : timer_q - TW'(1);
      end
   end

   // Compare value: the linear counter, or the counter with its bits reversed
   always_comb begin
      cnt_rev = '0;
      for (int i = 0; i < int'(SAMPLE_W); i++) begin
         cnt_rev[i] = cnt_q[SAMPLE_W-1-i];
      end
      cmp = (CNT_MODE == 0) ? cnt_q : cnt_rev;
   end

   // Per-channel push/pop decode and next occupancy
   always_comb begin
      for (int c = 0; c < int'(NUM_CH); c++) begin
         push[c]    = m_axis_aud_tvalid && m_axis_aud_tready && (m_axis_aud_tid == 3'(c));
         empty[c]   = (count_q[c] == '0);
         pop[c]     = frame_tick && !empty[c];
         count_d[c] = count_q[c] + CW'(push[c]) - CW'(pop[c]);
         full_d[c]  = (count_d[c] == CW'(FIFO_DEPTH));
      end
   end

   // Timer, counter and frame tick
   always_ff @(posedge m_axis_aud_aclk) begin
      if (m_axis_aud_areset) begin
         run_q      <= 1'b0;
         timer_q    <= TIMER_MAX;
         cnt_q      <= '0;
         frame_tick <= 1'b0;
      end else begin
         run_q      <= 1'b1;
         timer_q    <= timer_d;
         cnt_q      <= cnt_q + SAMPLE_W'(1);
         frame_tick <= (timer_d == '0);
      end
   end

   // FIFO pointers, sample hold registers and outputs
   always_ff @(posedge m_axis_aud_aclk) begin
      if (m_axis_aud_areset) begin
         m_axis_aud_tready <= 1'b0;
         pwm_out           <= '0;
         underrun          <= '0;
         for (int c = 0; c < int'(NUM_CH); c++) begin
            wr_ptr[c]     <= '0;
            rd_ptr[c]     <= '0;
            count_q[c]    <= '0;
            sample_reg[c] <= MID_SCALE;
         end
      end else begin
         m_axis_aud_tready <= ~|full_d;
         for (int c = 0; c < int'(NUM_CH); c++) begin
            count_q[c] <= count_d[c];
            if (push[c]) begin
               wr_ptr[c] <= wr_ptr[c] + AW'(1);
            end
            if (pop[c]) begin
               rd_ptr[c]     <= rd_ptr[c] + AW'(1);
               sample_reg[c] <= fifo_mem[c][rd_ptr[c]];
            end else if (frame_tick && (UNDERRUN_MODE != 0)) begin
               sample_reg[c] <= MID_SCALE;
            end
            underrun[c] <= frame_tick && empty[c];
            pwm_out[c]  <= (sample_reg[c] > cmp);
         end
      end
   end

   // Sample storage, no reset needed
   always_ff @(posedge m_axis_aud_aclk) begin
      for (int c = 0; c < int'(NUM_CH); c++) begin
         if (push[c]) begin
            fifo_mem[c][wr_ptr[c]] <= in_sample;
         end
      end
   end

endmodule

// File: tb/tb_pwm_modulator_mc.sv
// Bench for pwm_modulator_mc. Two instances share one stimulus stream:
// dut_a uses the linear counter and loads mid-scale on underrun.
// dut_b uses the bit-reversed counter and holds its sample on underrun.
// A frame-level scoreboard queues the expected sample for every accepted beat.
// It pops one entry per channel at each frame tick. The following 16-cycle
// window of each pwm_out is then checked against that sample.
module tb_pwm_modulator_mc;

   localparam logic [3:0] MID = 4'd8;

   logic       clk = 1'b0;
   logic       areset;
   logic       tvalid;
   logic [2:0] tid;
   logic [31:0] tdata;

   logic       tready_a, tick_a, tready_b, tick_b;
   logic [1:0] pwm_a, und_a, pwm_b, und_b;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   pwm_modulator_mc #(
      .NUM_CH(2), .SAMPLE_W(4), .FRAME_LEN(16), .FIFO_DEPTH(4),
      .CNT_MODE(0), .UNDERRUN_MODE(1)
   ) dut_a (
      .m_axis_aud_aclk(clk), .m_axis_aud_areset(areset),
      .m_axis_aud_tvalid(tvalid), .m_axis_aud_tid(tid), .m_axis_aud_tdata(tdata),
      .m_axis_aud_tready(tready_a), .pwm_out(pwm_a), .frame_tick(tick_a),
      .underrun(und_a)
   );

   pwm_modulator_mc #(
      .NUM_CH(2), .SAMPLE_W(4), .FRAME_LEN(16), .FIFO_DEPTH(4),
      .CNT_MODE(1), .UNDERRUN_MODE(0)
   ) dut_b (
      .m_axis_aud_aclk(clk), .m_axis_aud_areset(areset),
      .m_axis_aud_tvalid(tvalid), .m_axis_aud_tid(tid), .m_axis_aud_tdata(tdata),
      .m_axis_aud_tready(tready_b), .pwm_out(pwm_b), .frame_tick(tick_b),
      .underrun(und_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // ---------------- scoreboard / monitor ----------------
   logic       rst_q = 1'b0;
   int         cyc = 0;
   int         ticks = 0;
   logic       post_tick = 1'b0;
   logic [1:0] und_exp = '0;
   logic [3:0] exp_cur  [2][2];
   logic [3:0] exp_prev [2][2];
   logic [15:0] hist    [2][2];
   logic [3:0] q0[$];
   logic [3:0] q1[$];

   always @(posedge clk) rst_q <= areset;

   always @(negedge clk) begin
      logic       exp_tick;
      logic [1:0] pv [2];
      logic [1:0] uv [2];
      logic [15:0] h, older;
      logic [3:0] v;
      pv[0] = pwm_a; pv[1] = pwm_b;
      uv[0] = und_a; uv[1] = und_b;
      if (rst_q) begin
         chk("rst_pwm_a", 32'(pwm_a), 0);   chk("rst_pwm_b", 32'(pwm_b), 0);
         chk("rst_tready_a", 32'(tready_a), 0); chk("rst_tready_b", 32'(tready_b), 0);
         chk("rst_und_a", 32'(und_a), 0);   chk("rst_und_b", 32'(und_b), 0);
         chk("rst_tick_a", 32'(tick_a), 0); chk("rst_tick_b", 32'(tick_b), 0);
         q0.delete(); q1.delete();
         cyc = 0; ticks = 0; post_tick = 1'b0;
         for (int d = 0; d < 2; d++)
            for (int c = 0; c < 2; c++) begin
               exp_cur[d][c] = MID; exp_prev[d][c] = MID;
            end
      end else begin
         cyc++;
         exp_tick = (cyc % 16 == 0);
         chk("frame_tick_a", 32'(tick_a), 32'(exp_tick));
         chk("frame_tick_b", 32'(tick_b), 32'(exp_tick));
         chk("tready_a", 32'(tready_a), 32'(q0.size() < 4 && q1.size() < 4));
         chk("tready_b", 32'(tready_b), 32'(q0.size() < 4 && q1.size() < 4));
         for (int d = 0; d < 2; d++)
            for (int c = 0; c < 2; c++) begin
               chk($sformatf("underrun d%0d c%0d", d, c), 32'(uv[d][c]),
                   32'(post_tick ? und_exp[c] : 1'b0));
               hist[d][c] = {hist[d][c][14:0], pv[d][c]};
            end
         // Window of cycles T+2..T+17 after tick T reflects the sample loaded at T
         if (post_tick && ticks >= 2) begin
            for (int d = 0; d < 2; d++)
               for (int c = 0; c < 2; c++) begin
                  h     = hist[d][c];
                  older = {h[0], h[15:1]};
                  chk($sformatf("duty d%0d c%0d", d, c), 32'($countones(h)), 32'(exp_prev[d][c]));
                  if (d == 0 && exp_prev[d][c] != 0)
                     chk($sformatf("single_run c%0d", c), 32'($countones(h & ~older)), 1);
                  if (d == 1 && exp_prev[d][c] == MID)
                     chk($sformatf("toggle c%0d", c), 32'(h ^ older), 32'(16'hFFFF));
               end
         end
         post_tick = 1'b0;
         if (exp_tick && !areset) begin
            ticks++;
            post_tick = 1'b1;
            for (int d = 0; d < 2; d++)
               for (int c = 0; c < 2; c++) exp_prev[d][c] = exp_cur[d][c];
            if (q0.size() != 0) begin
               v = q0.pop_front(); exp_cur[0][0] = v; exp_cur[1][0] = v; und_exp[0] = 1'b0;
            end else begin
               exp_cur[0][0] = MID; und_exp[0] = 1'b1;
            end
            if (q1.size() != 0) begin
               v = q1.pop_front(); exp_cur[0][1] = v; exp_cur[1][1] = v; und_exp[1] = 1'b0;
            end else begin
               exp_cur[0][1] = MID; und_exp[1] = 1'b1;
            end
         end
         if (tvalid && tready_a && !areset) begin
            if (tid == 3'd0) q0.push_back(tdata[27:24] ^ 4'b1000);
            if (tid == 3'd1) q1.push_back(tdata[27:24] ^ 4'b1000);
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic sync();
      @(posedge clk);
      #1;
   endtask

   // Present one beat and hold it until it transfers; tvalid is left high.
   task automatic beat(input logic [2:0] id, input logic [3:0] s, output int waited);
      logic acc;
      acc = 1'b0;
      waited = 0;
      tvalid = 1'b1;
      tid    = id;
      tdata  = {4'($urandom), s, 24'($urandom)};
      while (!acc && waited < 64) begin
         @(negedge clk);
         acc = tready_a;
         @(posedge clk);
         #1;
         waited++;
      end
      chk("beat_accepted", 32'(acc), 1);
   endtask

   task automatic wait_ticks(input int n);
      int   i;
      logic seen;
      for (int k = 0; k < n; k++) begin
         i = 0;
         seen = 1'b0;
         while (!seen && i < 40) begin
            @(negedge clk);
            seen = tick_a;
            i++;
         end
         chk("tick_wait", 32'(seen), 1);
      end
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int w;
      logic [3:0] burst [5];
      burst[0] = 4'b0001; burst[1] = 4'b0010; burst[2] = 4'b0011;
      burst[3] = 4'b0110; burst[4] = 4'b1111;

      areset = 1'b1; tvalid = 1'b0; tid = '0; tdata = '0;
      repeat (3) @(posedge clk);
      #1 areset = 1'b0;

      // +4 on ch0 before the first tick, ch1 left at mid-scale
      sync();
      beat(3'd0, 4'b0100, w);
      tvalid = 1'b0;
      wait_ticks(2);

      // -8 (offset 0) on ch1, +7 on ch0
      sync();
      beat(3'd1, 4'b1000, w);
      beat(3'd0, 4'b0111, w);
      tvalid = 1'b0;
      wait_ticks(2);

      // Burst of 5 to ch1 right after a tick: 4 fit, the 5th waits for the pop
      wait_ticks(1);
      sync();
      for (int i = 0; i < 4; i++) begin
         beat(3'd1, burst[i], w);
         chk("burst_wait", 32'(w), 1);
      end
      @(negedge clk);
      chk("tready_full", 32'(tready_a), 0);
      @(posedge clk);
      #1;
      beat(3'd1, burst[4], w);
      chk("burst5_wait", 32'(w), 12);
      tvalid = 1'b0;
      wait_ticks(6);

      // ch0 sample 3, then starve it
      sync();
      beat(3'd0, 4'b1011, w);
      tvalid = 1'b0;
      wait_ticks(3);

      // Out-of-range tid is accepted immediately and dropped
      sync();
      beat(3'd5, 4'b0111, w);
      chk("tid5_wait", 32'(w), 1);
      tvalid = 1'b0;
      wait_ticks(2);

      // Reset mid-frame with two samples queued
      wait_ticks(1);
      sync();
      beat(3'd0, 4'b0001, w);
      beat(3'd1, 4'b0010, w);
      tvalid = 1'b0;
      repeat (3) sync();
      areset = 1'b1;
      sync();
      areset = 1'b0;
      wait_ticks(3);
      repeat (4) sync();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
